mem_access_stage: RTL and testbench

//  MEM-stage controller sitting directly downstream of the EX/MEM pipeline register. Turns MemtoRegM/MemWriteM

---
 rtl/mem_access_stage_pkg.sv | 18 +
 rtl/mem_access_stage_if.sv | 22 ++
 rtl/mem_timeout_counter.sv | 29 ++
 rtl/mem_access_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM-stage data-memory controller: FSM encodings,
// timeout counter width and the value returned on a bus error.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam int          TMO_W        = 8;
  localparam logic [31:0] BUSERR_RDATA = 32'h0;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge data-memory port between the MEM stage (master) and the
// data memory (slave).
interface mem_access_stage_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_timeout_counter.sv
// Busy-cycle counter for the MEM stage: synchronous clear, count enable and a
// terminal-count flag raised when the count reaches TIMEOUT_CYCLES-1.
module mem_timeout_counter
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic Reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: issues one req/ack transaction per load/store and stalls
// the pipeline until it completes. Optional trap: MEM_MISALIGN_TRAP_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      Reset,
  input  logic                      MemtoRegM,
  input  logic                      MemWriteM,
  input  logic [31:0]               ALUOutM,
  input  logic [31:0]               WriteDataM,
  mem_access_stage_if.master        mem,
  output logic [31:0]               ReadDataM,
  output logic                      StallM,
  output logic                      BusErrM,
  output logic                      MisalignM
);

  mem_state_e  r_state;
  mem_state_e  w_next;

  logic        w_access;
  logic        w_misalign;
  logic        w_issue;
  logic        w_trap;
  logic        w_ack_done;
  logic        w_timeout;
  logic        w_cnt_en;
  logic        w_tc;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_buserr;

  assign w_access = MemtoRegM | MemWriteM;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = |ALUOutM[1:0];
`else
  logic w_unused_lo_bits;
  assign w_unused_lo_bits = ^ALUOutM[1:0];
  assign w_misalign       = 1'b0;
`endif

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          w_next = w_misalign ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem.mem_ack || w_tc) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // A same-cycle ack always beats the timeout.
  always_comb begin
    StallM     = 1'b0;
    w_issue    = 1'b0;
    w_trap     = 1'b0;
    w_ack_done = 1'b0;
    w_timeout  = 1'b0;
    w_cnt_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        StallM  = w_access;
        w_issue = w_access & ~w_misalign;
        w_trap  = w_access &  w_misalign;
      end
      ST_BUSY: begin
        StallM     = 1'b1;
        w_ack_done = mem.mem_ack;
        w_timeout  = ~mem.mem_ack & w_tc;
        w_cnt_en   = ~mem.mem_ack;
      end
      default: ;
    endcase
  end

  mem_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk   (clk),
    .Reset (Reset),
    .i_clr (w_issue),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_issue) begin
      r_req   <= 1'b1;
      r_we    <= MemWriteM;
      r_addr  <= word_addr(ALUOutM);
      r_wdata <= WriteDataM;
    end else if (w_ack_done || w_timeout) begin
      r_req   <= 1'b0;
    end
  end

  // ReadDataM is sticky: only a completed load, a timeout or a trap changes it.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_rdata  <= '0;
      r_buserr <= 1'b0;
    end else begin
      r_buserr <= w_timeout;
      if (w_ack_done && !r_we) begin
        r_rdata <= mem.mem_rdata;
      end else if (w_timeout || w_trap) begin
        r_rdata <= BUSERR_RDATA;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_trap;
    end
  end

  assign MisalignM = r_misalign;
`else
  assign MisalignM = 1'b0;
`endif

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign ReadDataM     = r_rdata;
  assign BusErrM       = r_buserr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT_CYCLES=4; the bench plays the
// data memory and checks stall length, bus fields and returned data per access.
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk        = 1'b0;
  logic        Reset      = 1'b0;
  logic        MemtoRegM  = 1'b0;
  logic        MemWriteM  = 1'b0;
  logic [31:0] ALUOutM    = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        BusErrM;
  logic        MisalignM;

  int checks = 0;
  int errors = 0;
  int nreq   = 0;
  logic prev_req = 1'b0;

  int          a_stalls;
  int          a_busy;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [31:0] a_rd;
  logic        a_we;
  logic        a_berr;
  logic        a_mis;
  logic        a_done;

  mem_access_stage_if u_bus ();

  mem_access_stage #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .mem        (u_bus),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .BusErrM    (BusErrM),
    .MisalignM  (MisalignM)
  );

  always #5 clk = ~clk;

  // Counts distinct request transactions (rising edges of mem_req).
  always @(negedge clk) begin
    if (u_bus.mem_req && !prev_req) nreq++;
    prev_req = u_bus.mem_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    MemtoRegM = 1'b0;
    MemWriteM = 1'b0;
  endtask

  // Presents one instruction at the next IDLE cycle, acks after ack_after extra
  // BUSY cycles (negative = never) and returns during the DONE cycle.
  task automatic do_access(input logic ld, input logic st, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdv, input int ack_after);
    @(posedge clk); #1;
    MemtoRegM  = ld;
    MemWriteM  = st;
    ALUOutM    = addr;
    WriteDataM = wd;
    a_stalls = 0; a_busy = 0; a_done = 1'b0;
    a_addr = '0; a_wdata = '0; a_we = 1'b0; a_rd = '0; a_berr = 1'b0; a_mis = 1'b0;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (StallM) a_stalls++;
      if (c > 0 && !StallM) begin
        a_done = 1'b1;
        a_rd   = ReadDataM;
        a_berr = BusErrM;
        a_mis  = MisalignM;
        break;
      end
      if (u_bus.mem_req) begin
        a_busy++;
        a_addr  = u_bus.mem_addr;
        a_we    = u_bus.mem_we;
        a_wdata = u_bus.mem_wdata;
        if (a_busy - 1 == ack_after) begin
          u_bus.mem_ack   = 1'b1;
          u_bus.mem_rdata = rdv;
        end
      end
      @(posedge clk); #1;
      u_bus.mem_ack = 1'b0;
    end
    chk("done_reached", 32'(a_done), 32'd1);
  endtask

  initial begin
    int n0;
    u_bus.mem_ack   = 1'b0;
    u_bus.mem_rdata = '0;

    #12;
    chk("rst_req",    32'(u_bus.mem_req), 0);
    chk("rst_we",     32'(u_bus.mem_we), 0);
    chk("rst_addr",   u_bus.mem_addr, 0);
    chk("rst_wdata",  u_bus.mem_wdata, 0);
    chk("rst_rdata",  ReadDataM, 0);
    chk("rst_stall",  32'(StallM), 0);
    chk("rst_buserr", 32'(BusErrM), 0);
    chk("rst_mis",    32'(MisalignM), 0);
    #10 Reset = 1'b1;

    // Load, immediate ack
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 32'h12345678, 0);
    clr_in();
    chk("ld_stalls", a_stalls, 2);
    chk("ld_busy",   a_busy, 1);
    chk("ld_addr",   a_addr, 32'h100);
    chk("ld_we",     32'(a_we), 0);
    chk("ld_rdata",  a_rd, 32'h12345678);
    chk("ld_berr",   32'(a_berr), 0);

    // Store, ack in 4th BUSY cycle (also the terminal-count cycle)
    do_access(1'b0, 1'b1, 32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 3);
    clr_in();
    chk("st_stalls", a_stalls, 5);
    chk("st_busy",   a_busy, 4);
    chk("st_addr",   a_addr, 32'h204);
    chk("st_we",     32'(a_we), 1);
    chk("st_wdata",  a_wdata, 32'hCAFEF00D);
    chk("st_rdata",  a_rd, 32'h12345678);
    chk("st_berr",   32'(a_berr), 0);

    // Load with no ack: timeout
    do_access(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, -1);
    clr_in();
    chk("to_busy",   a_busy, 4);
    chk("to_stalls", a_stalls, 5);
    chk("to_berr",   32'(a_berr), 1);
    chk("to_rdata",  a_rd, 32'h0);
    @(posedge clk); #1;
    chk("to_berr_pulse", 32'(BusErrM), 0);
    chk("to_req_low",    32'(u_bus.mem_req), 0);
    chk("to_no_stall",   32'(StallM), 0);

    // Load acked in the terminal cycle
    do_access(1'b1, 1'b0, 32'h308, 32'h0, 32'hA5A50001, 3);
    clr_in();
    chk("tc_ack_berr",  32'(a_berr), 0);
    chk("tc_ack_rdata", a_rd, 32'hA5A50001);
    chk("tc_ack_busy",  a_busy, 4);

    // Back-to-back loads; first stays on the inputs through DONE
    n0 = nreq;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h11110010, 0);
    chk("b2b0_rdata", a_rd, 32'h11110010);
    chk("b2b0_addr",  a_addr, 32'h10);
    do_access(1'b1, 1'b0, 32'h14, 32'h0, 32'h22220014, 0);
    clr_in();
    chk("b2b1_rdata",  a_rd, 32'h22220014);
    chk("b2b1_addr",   a_addr, 32'h14);
    chk("b2b1_stalls", a_stalls, 2);
    @(negedge clk); @(negedge clk);
    chk("b2b_nreq", nreq - n0, 2);

    // Load and store together -> store
    do_access(1'b1, 1'b1, 32'h400, 32'h55AA55AA, 32'h0BAD0BAD, 0);
    clr_in();
    chk("both_we",    32'(a_we), 1);
    chk("both_rdata", a_rd, 32'h22220014);

    // Non-memory instructions never stall
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ALUOutM = 32'h1000 + 32'(i * 4);
      #1;
      chk("nomem_stall", 32'(StallM), 0);
      chk("nomem_req",   32'(u_bus.mem_req), 0);
    end

    // Misaligned load
    n0 = nreq;
    do_access(1'b1, 1'b0, 32'h102, 32'h0, 32'h0F0F0F0F, 0);
    clr_in();
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_stalls", a_stalls, 1);
    chk("mis_busy",   a_busy, 0);
    chk("mis_flag",   32'(a_mis), 1);
    chk("mis_rdata",  a_rd, 32'h0);
    @(negedge clk);
    chk("mis_nreq",   nreq - n0, 0);
`else
    chk("mis_addr",   a_addr, 32'h100);
    chk("mis_busy",   a_busy, 1);
    chk("mis_flag",   32'(a_mis), 0);
    chk("mis_rdata",  a_rd, 32'h0F0F0F0F);
    @(negedge clk);
    chk("mis_nreq",   nreq - n0, 1);
`endif

    // Reset while BUSY; late ack after release is ignored
    @(posedge clk); #1;
    MemtoRegM = 1'b1;
    ALUOutM   = 32'h40;
    @(posedge clk); #1;
    chk("rb_req_busy", 32'(u_bus.mem_req), 1);
    clr_in();
    #2 Reset = 1'b0;
    #1;
    chk("rb_req",   32'(u_bus.mem_req), 0);
    chk("rb_addr",  u_bus.mem_addr, 0);
    chk("rb_rdata", ReadDataM, 0);
    chk("rb_stall", 32'(StallM), 0);
    @(posedge clk); #1;
    Reset = 1'b1;
    @(posedge clk); #1;
    u_bus.mem_ack   = 1'b1;
    u_bus.mem_rdata = 32'hDEADBEEF;
    #1;
    chk("rb_late_stall", 32'(StallM), 0);
    @(posedge clk); #1;
    u_bus.mem_ack = 1'b0;
    chk("rb_late_rdata", ReadDataM, 0);
    chk("rb_late_req",   32'(u_bus.mem_req), 0);
    chk("rb_late_berr",  32'(BusErrM), 0);

    // Normal operation resumes after reset
    do_access(1'b1, 1'b0, 32'h80, 32'h0, 32'h13572468, 0);
    clr_in();
    chk("post_rst_rdata",  a_rd, 32'h13572468);
    chk("post_rst_stalls", a_stalls, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
